// File: rtl/oa21_stim_checker.sv
// Stimulus driver and response checker for an OA21 cell, Q = (IN1|IN2) & IN3.
// Drives registered vectors, waits a settle window, samples Q and counts mismatches/toggles.
module oa21_stim_checker #(
  parameter int unsigned NUM_VECTORS   = 64,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned LFSR_MODE     = 0,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             drv_in1,
  output logic             drv_in2,
  output logic             drv_in3,
  input  logic             q_sense,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] tog_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]    SETTLE_INIT = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0]    SETTLE_ONE  = SW'(1);
  localparam logic [CNT_W-1:0] LAST_VEC    = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t          state;
  logic [SW-1:0]   settle_cnt;
  logic [7:0]      lfsr;
  logic [7:0]      lfsr_next;
  logic [2:0]      ecount;
  logic [2:0]      vec;
  logic            prev_q;
  logic            expected;

  // Fibonacci x^8+x^6+x^5+x^4+1, shifting left: taps at bits 7,5,4,3.
  always_comb begin
    lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    vec       = (LFSR_MODE != 0) ? lfsr[2:0] : ecount;
    expected  = (drv_in1 | drv_in2) & drv_in3;
  end

  assign pass = done & (err_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      lfsr       <= 8'h01;
      ecount     <= '0;
      prev_q     <= 1'b0;
      drv_in1    <= 1'b0;
      drv_in2    <= 1'b0;
      drv_in3    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      vec_cnt    <= '0;
      err_cnt    <= '0;
      tog_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            vec_cnt <= '0;
            err_cnt <= '0;
            tog_cnt <= '0;
            done    <= 1'b0;
            prev_q  <= 1'b0;
            lfsr    <= 8'h01;
            ecount  <= '0;
            busy    <= 1'b1;
            state   <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          drv_in1    <= vec[0];
          drv_in2    <= vec[1];
          drv_in3    <= vec[2];
          lfsr       <= lfsr_next;
          ecount     <= ecount + 3'd1;
          settle_cnt <= SETTLE_INIT;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - SETTLE_ONE;
          end
        end
        S_SAMPLE: begin
          if ((q_sense != expected) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_ONE;
          end
          if ((q_sense != prev_q) && (tog_cnt != '1)) begin
            tog_cnt <= tog_cnt + CNT_ONE;
          end
          prev_q  <= q_sense;
          vec_cnt <= vec_cnt + CNT_ONE;
          if (vec_cnt == LAST_VEC) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            state <= S_DRIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oa21_stim_checker.sv
// Bench for oa21_stim_checker: table-driven full runs plus reset, restart and LFSR sequences.
module tb_oa21_stim_checker;

  logic        clk = 1'b0;
  logic        rst, start, start6;
  logic        d1, d2, d3, q_sense;
  logic        busy, done, pass;
  logic [15:0] vc, ec, tc;
  logic        e1, e2, e3, q6;
  logic        busy6, done6, pass6;
  logic [15:0] vc6, ec6, tc6;
  int unsigned qmode;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  typedef struct {
    int unsigned qmode;
    int unsigned vec;
    int unsigned err;
    int unsigned tog;
    logic        pass;
  } vec_t;

  vec_t       tbl[3];
  logic [2:0] exp6[8];

  always #5 clk = ~clk;

  // 0: ideal OA21 cell, 1: Q stuck at 0, 2: Q stuck at 1
  always_comb begin
    q_sense = 1'b0;
    case (qmode)
      0:       q_sense = (d1 | d2) & d3;
      2:       q_sense = 1'b1;
      default: q_sense = 1'b0;
    endcase
  end
  assign q6 = (e1 | e2) & e3;

  oa21_stim_checker dut (
    .clk(clk), .rst(rst), .start(start),
    .drv_in1(d1), .drv_in2(d2), .drv_in3(d3), .q_sense(q_sense),
    .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vc), .err_cnt(ec), .tog_cnt(tc)
  );

  oa21_stim_checker #(.NUM_VECTORS(8), .SETTLE_CYCLES(1), .LFSR_MODE(1)) dut6 (
    .clk(clk), .rst(rst), .start(start6),
    .drv_in1(e1), .drv_in2(e2), .drv_in3(e3), .q_sense(q6),
    .busy(busy6), .done(done6), .pass(pass6),
    .vec_cnt(vc6), .err_cnt(ec6), .tog_cnt(tc6)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " drv"},  {29'd0, d3, d2, d1}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " done"}, {31'd0, done}, 32'd0);
    chk({tag, " pass"}, {31'd0, pass}, 32'd0);
    chk({tag, " vec"},  {16'd0, vc}, 32'd0);
    chk({tag, " err"},  {16'd0, ec}, 32'd0);
    chk({tag, " tog"},  {16'd0, tc}, 32'd0);
  endtask

  // Returns at the negedge after the START edge; that edge is counted as edge 1.
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned from_edge, input int unsigned budget,
                           output int unsigned edges);
    edges = from_edge;
    while (!done && edges < budget) begin
      @(negedge clk);
      edges++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned e;
    int unsigned k;
    int unsigned d6e;

    tbl[0] = '{qmode: 0, vec: 64, err: 0,  tog: 15, pass: 1'b1};
    tbl[1] = '{qmode: 1, vec: 64, err: 24, tog: 0,  pass: 1'b0};
    tbl[2] = '{qmode: 2, vec: 64, err: 40, tog: 1,  pass: 1'b0};
    exp6[0] = 3'd1; exp6[1] = 3'd2; exp6[2] = 3'd4; exp6[3] = 3'd0;
    exp6[4] = 3'd1; exp6[5] = 3'd3; exp6[6] = 3'd7; exp6[7] = 3'd6;

    rst = 1'b1; start = 1'b0; start6 = 1'b0; qmode = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      qmode = tbl[i].qmode;
      pulse_start();
      chk($sformatf("run%0d busy", i), {31'd0, busy}, 32'd1);
      wait_done(1, 400, e);
      chk($sformatf("run%0d done edge", i), e, 32'd257);
      chk($sformatf("run%0d vec", i), {16'd0, vc}, tbl[i].vec);
      chk($sformatf("run%0d err", i), {16'd0, ec}, tbl[i].err);
      chk($sformatf("run%0d tog", i), {16'd0, tc}, tbl[i].tog);
      chk($sformatf("run%0d pass", i), {31'd0, pass}, {31'd0, tbl[i].pass});
      chk($sformatf("run%0d busy end", i), {31'd0, busy}, 32'd0);
      chk($sformatf("run%0d last drv", i), {29'd0, d3, d2, d1}, 32'd7);
    end

    // Reset at edge 40 of a run, then a clean run
    qmode = 0;
    pulse_start();
    repeat (38) @(negedge clk);
    chk("midrun vec", {16'd0, vc}, 32'd9);
    chk("midrun busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrun reset");
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("abandoned done", {31'd0, done}, 32'd0);
    pulse_start();
    wait_done(1, 400, e);
    chk("rerun done edge", e, 32'd257);
    chk("rerun pass", {31'd0, pass}, 32'd1);
    chk("rerun tog", {16'd0, tc}, 32'd15);

    // START while busy is ignored; START in DONE restarts with cleared counters
    pulse_start();
    repeat (19) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(21, 400, e);
    chk("ignored start done edge", e, 32'd257);
    chk("ignored start vec", {16'd0, vc}, 32'd64);
    chk("ignored start err", {16'd0, ec}, 32'd0);
    chk("ignored start tog", {16'd0, tc}, 32'd15);
    qmode = 1;
    pulse_start();
    chk("restart vec clr", {16'd0, vc}, 32'd0);
    chk("restart tog clr", {16'd0, tc}, 32'd0);
    chk("restart done clr", {31'd0, done}, 32'd0);
    chk("restart busy", {31'd0, busy}, 32'd1);
    wait_done(1, 400, e);
    chk("restart done edge", e, 32'd257);
    chk("restart err", {16'd0, ec}, 32'd24);

    // LFSR source, 1 settle cycle, 8 vectors
    @(negedge clk) start6 = 1'b1;
    @(negedge clk) start6 = 1'b0;
    e = 1; k = 0; d6e = 0;
    while (e < 40 && d6e == 0) begin
      if (k < 8 && e == 2 + 3 * k) begin
        chk($sformatf("lfsr drv%0d", k), {29'd0, e3, e2, e1}, {29'd0, exp6[k]});
        k++;
      end
      if (done6) d6e = e;
      else begin
        @(negedge clk);
        e++;
      end
    end
    chk("lfsr vectors seen", k, 32'd8);
    chk("lfsr done edge", d6e, 32'd25);
    chk("lfsr pass", {31'd0, pass6}, 32'd1);
    chk("lfsr vec", {16'd0, vc6}, 32'd8);
    chk("lfsr err", {16'd0, ec6}, 32'd0);
    chk("lfsr tog", {16'd0, tc6}, 32'd1);
    chk("lfsr busy end", {31'd0, busy6}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
